// File: rtl/pipeline_trace_buffer.sv
// Retirement trace buffer: circular capture of {pc, instr}, trigger on a PC match,
// post-trigger window, then oldest-first readout. Optional timestamps: TRACE_TIMESTAMP_EN.
module pipeline_trace_buffer #(
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32,
   parameter int DEPTH   = 16,
   parameter int TS_W    = 16,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cap_valid,
   input  logic [PC_W-1:0]    cap_pc,
   input  logic [INSTR_W-1:0] cap_instr,
   input  logic               arm,
   input  logic [PC_W-1:0]    trig_pc,
   input  logic [AW-1:0]      post_cnt,
   input  logic               rd_en,
   output logic               rd_valid,
   output logic [PC_W-1:0]    rd_pc,
   output logic [INSTR_W-1:0] rd_instr,
`ifdef TRACE_TIMESTAMP_EN
   output logic [TS_W-1:0]    rd_ts,
`endif
   output logic [1:0]         state,
   output logic [AW:0]        count
);

   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || TS_W < 1) begin : g_bad_param
      $error("pipeline_trace_buffer: DEPTH must be a power of two >= 4 and TS_W >= 1");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ARMED = 2'b01,
      POST  = 2'b10,
      DONE  = 2'b11
   } state_t;

   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

   state_t               state_q, state_d;
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW:0]          count_q, count_d;
   logic [AW-1:0]        post_q, post_d;
   logic                 rd_valid_q;
   logic [PC_W-1:0]      rd_pc_q;
   logic [INSTR_W-1:0]   rd_instr_q;

   logic                 wr_en;
   logic                 rd_fire;
   logic [AW-1:0]        rd_ptr;

   logic [PC_W-1:0]      mem_pc    [DEPTH];
   logic [INSTR_W-1:0]   mem_instr [DEPTH];

   // Oldest entry sits count slots behind the write pointer; a full buffer wraps to wr_ptr itself.
   assign rd_ptr = wr_ptr_q - count_q[AW-1:0];

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      post_d   = post_q;
      wr_en    = 1'b0;
      rd_fire  = 1'b0;
      if (arm) begin
         state_d  = ARMED;
         wr_ptr_d = '0;
         count_d  = '0;
         post_d   = '0;
      end else begin
         case (state_q)
            ARMED, POST: begin
               if (cap_valid) begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  if (count_q != FULL) count_d = count_q + 1'b1;
                  if (state_q == ARMED) begin
                     if (cap_pc == trig_pc) begin
                        if (post_cnt == '0) begin
                           state_d = DONE;
                        end else begin
                           post_d  = post_cnt;
                           state_d = POST;
                        end
                     end
                  end else begin
                     post_d = post_q - 1'b1;
                     if (post_q == AW'(1)) state_d = DONE;
                  end
               end
            end
            DONE: begin
               if (rd_en && count_q != '0) begin
                  rd_fire = 1'b1;
                  count_d = count_q - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         count_q  <= '0;
         post_q   <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         post_q   <= post_d;
      end
   end

   // Storage is never reset; only the pointers give it meaning.
   always_ff @(posedge clk) begin
      if (wr_en && reset) begin
         mem_pc[wr_ptr_q]    <= cap_pc;
         mem_instr[wr_ptr_q] <= cap_instr;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_valid_q <= 1'b0;
         rd_pc_q    <= '0;
         rd_instr_q <= '0;
      end else begin
         rd_valid_q <= rd_fire;
         if (rd_fire) begin
            rd_pc_q    <= mem_pc[rd_ptr];
            rd_instr_q <= mem_instr[rd_ptr];
         end
      end
   end

`ifdef TRACE_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q;
   logic [TS_W-1:0] rd_ts_q;
   logic [TS_W-1:0] mem_ts [DEPTH];

   always_ff @(posedge clk) begin
      if (!reset) ts_q <= '0;
      else        ts_q <= ts_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (wr_en && reset) mem_ts[wr_ptr_q] <= ts_q;
   end

   always_ff @(posedge clk) begin
      if (!reset)       rd_ts_q <= '0;
      else if (rd_fire) rd_ts_q <= mem_ts[rd_ptr];
   end

   assign rd_ts = rd_ts_q;
`endif

   assign rd_valid = rd_valid_q;
   assign rd_pc    = rd_pc_q;
   assign rd_instr = rd_instr_q;
   assign state    = state_q;
   assign count    = count_q;

endmodule

// File: doc/pipeline_trace_buffer.md
PIPELINE_TRACE_BUFFER -- requirements
Module: pipeline_trace_buffer

Interface
REQ-001 SHALL have parameter PC_W, default 32, PC width of captured entries.
REQ-002 SHALL have parameter INSTR_W, default 32, instruction width of captured entries.
REQ-003 SHALL have parameter DEPTH, default 16, entry count, power of two >= 4; AW = log2(DEPTH).
REQ-004 SHALL have parameter TS_W, default 16, timestamp width (used only under TRACE_TIMESTAMP_EN).
REQ-005 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-low reset (0 = reset).
REQ-007 SHALL have port cap_valid  in  1  retiring instruction present this cycle.
REQ-008 SHALL have port cap_pc  in  PC_W  PC of the retiring instruction.
REQ-009 SHALL have port cap_instr  in  INSTR_W  encoding of the retiring instruction.
REQ-010 SHALL have port arm  in  1  single-cycle pulse: clear buffer and start capture.
REQ-011 SHALL have port trig_pc  in  PC_W  trigger PC, compared live.
REQ-012 SHALL have port post_cnt  in  AW  entries to capture after the trigger entry.
REQ-013 SHALL have port rd_en  in  1  pop request for the oldest entry.
REQ-014 SHALL have port rd_valid  out  1  rd_pc/rd_instr hold a popped entry this cycle.
REQ-015 SHALL have port rd_pc  out  PC_W  popped PC.
REQ-016 SHALL have port rd_instr  out  INSTR_W  popped instruction.
REQ-017 SHALL have port state  out  2  IDLE=00, ARMED=01, POST=10, DONE=11.
REQ-018 SHALL have port count  out  AW+1  valid entries held, 0..DEPTH.

Function
REQ-019 IDLE: cap_valid and rd_en SHALL be ignored; arm SHALL move to ARMED next cycle with wr_ptr=0, count=0.
REQ-020 ARMED/POST: each cap_valid SHALL write {cap_pc, cap_instr} at wr_ptr; wr_ptr increments mod DEPTH; count increments, saturating at DEPTH (oldest entry overwritten).
REQ-021 ARMED: cap_valid with cap_pc==trig_pc SHALL write that entry and go to DONE if post_cnt==0, else load post counter with post_cnt and go to POST.
REQ-022 POST: each cap_valid SHALL write and decrement the post counter; the write taking it to 0 SHALL move to DONE next cycle; trigger matches in POST SHALL be ignored.
REQ-023 post_cnt SHALL be sampled only at the trigger cycle; max value DEPTH-1 guarantees the trigger entry survives.
REQ-024 DONE: capture SHALL stop; rd_en with count>0 SHALL pop the oldest entry at index (wr_ptr-count) mod DEPTH and decrement count.
REQ-025 Read latency SHALL be one cycle: rd_valid high for exactly one cycle after each accepted pop, data registered.
REQ-026 rd_en with count==0, or outside DONE, SHALL be ignored (rd_valid stays 0); back-to-back rd_en SHALL pop one entry per cycle.
REQ-027 arm in any state, including mid-POST or mid-readout, SHALL restart (wr_ptr=0, count=0, ARMED) and take priority over cap_valid and rd_en that cycle.
REQ-028 Entries SHALL be popped in capture order; the last popped entry SHALL be the final POST entry (or trigger entry when post_cnt==0).

Reset
REQ-029 reset==0 at a clock edge SHALL force state=IDLE, wr_ptr=0, count=0, post counter=0, rd_valid=0, rd_pc=0, rd_instr=0 (and rd_ts=0, timestamp counter=0 when enabled).
REQ-030 Storage array contents SHALL NOT be reset; reset SHALL take priority over arm and all other inputs.

Configuration
REQ-031 Macro TRACE_TIMESTAMP_EN defined: a TS_W-bit free-running cycle counter (wraps to 0) SHALL be stored with each entry and returned on output rd_ts (TS_W), valid with rd_valid.
REQ-032 TRACE_TIMESTAMP_EN undefined: no counter, no timestamp storage, no rd_ts port; all other behaviour identical.

Verification (DEPTH=8)
REQ-033 Reset low 2 cycles, then arm; retire PCs 0x00,0x04..0x1C with trig_pc=0x10, post_cnt=2 -> DONE after 0x18; 7 pops return 0x00..0x18 in order, count 7->0.
REQ-034 Retire 20 PCs 0x00..0x4C, trig_pc=0x40, post_cnt=3 -> count=8 saturated; pops return 0x30..0x4C (wrap/overwrite).
REQ-035 post_cnt=0, trigger on first capture 0x100 -> DONE next cycle, count=1, one pop returns 0x100, further rd_en gives rd_valid=0.
REQ-036 arm pulsed during POST with cap_valid=1 -> state=ARMED, count=0 next cycle, that capture discarded.
REQ-037 Reset asserted mid-readout (count=5) -> state=IDLE, count=0, rd_valid=0 next cycle; rd_en then ignored.
REQ-038 With TRACE_TIMESTAMP_EN, captures at cycles 10 and 13 after reset -> popped rd_ts differ by 3.
